// File: rtl/count_sched_pkg.sv
// rtl/count_sched_pkg.sv - shared types, default widths and bus lane helper for count_sched_ctrl
package count_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } sched_state_e;

    localparam int DEF_NUM_REQ = 3;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_STEP_W  = 4;
    localparam int BUS_MAX_W   = 256;

    // Callers zero-extend their flattened bus to BUS_MAX_W and truncate the result to the lane width.
    function automatic logic [31:0] get_lane(input logic [BUS_MAX_W-1:0] bus, input int idx, input int w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return 32'(bus >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/count_sched_ctrl_if.sv
// rtl/count_sched_ctrl_if.sv - requester bump handshake between stimulus sources and count_sched_ctrl
interface count_sched_ctrl_if #(
    parameter int NUM_REQ = 3,
    parameter int STEP_W  = 4
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*STEP_W-1:0] req_step;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (output req_valid, output req_step, input req_ready);
    modport slave  (input req_valid, input req_step, output req_ready);
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first requester at or after ptr, with wrap
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic          found;
    logic [PW:0]   pos;
    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pos   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (PW+1)'(k);
            if (pos >= (PW+1)'(N)) begin
                pos = pos - (PW+1)'(N);
            end
            idx = pos[PW-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_sched_ctrl.sv
// rtl/count_sched_ctrl.sv - shared-adder event counter scheduler; COUNT_SAT_EN selects saturating counts
module count_sched_ctrl
    import count_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int STEP_W  = DEF_STEP_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     clr,
    count_sched_ctrl_if.slave        req_if,
    output logic [NUM_REQ*CNT_W-1:0] count,
    output logic [NUM_REQ-1:0]       ovf,
    output logic                     busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    sched_state_e     state_q, state_d;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] clr_idx_q;
    logic [CNT_W-1:0] cnt_q [NUM_REQ];
    logic [NUM_REQ-1:0] ovf_q;
    logic [NUM_REQ-1:0] gnt;

    logic             xfer;
    logic             clr_last;
    logic [PTR_W-1:0] gnt_idx;
    logic [CNT_W-1:0] cur_cnt;
    logic [STEP_W-1:0] cur_step;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] new_cnt;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req (req_if.req_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    // A clear request pre-empts the grant so the pending requester stays queued.
    assign req_if.req_ready = (state_q == RUN && !clr) ? gnt : '0;
    assign xfer             = |(req_if.req_valid & req_if.req_ready);
    assign clr_last         = (clr_idx_q == PTR_W'(NUM_REQ-1));

    always_comb begin
        gnt_idx  = '0;
        cur_cnt  = '0;
        cur_step = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_if.req_ready[i]) begin
                gnt_idx  = PTR_W'(i);
                cur_cnt  = cnt_q[i];
                cur_step = STEP_W'(get_lane(BUS_MAX_W'(req_if.req_step), i, STEP_W));
            end
        end
        sum = {1'b0, cur_cnt} + (CNT_W+1)'(cur_step);
`ifdef COUNT_SAT_EN
        new_cnt = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
`else
        new_cnt = sum[CNT_W-1:0];
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (clr)     state_d = CLEAR;
                else if (en) state_d = RUN;
            end
            RUN: begin
                if (clr)      state_d = CLEAR;
                else if (!en) state_d = IDLE;
            end
            CLEAR: begin
                if (clr_last) state_d = en ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            clr_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                ptr_q <= (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + PTR_W'(1);
            end
            if (state_q == CLEAR) begin
                clr_idx_q <= clr_last ? '0 : clr_idx_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (state_q == CLEAR && clr_idx_q == PTR_W'(i)) begin
                    cnt_q[i] <= '0;
                    ovf_q[i] <= 1'b0;
                end else if (xfer && gnt_idx == PTR_W'(i)) begin
                    cnt_q[i] <= new_cnt;
                    if (sum[CNT_W]) ovf_q[i] <= 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_count
        assign count[i*CNT_W +: CNT_W] = cnt_q[i];
    end

    assign ovf  = ovf_q;
    assign busy = (state_q == CLEAR);

endmodule
